// File: rtl/image_process.sv
// Single-cycle RGB pixel processor: pass, brightness up/down, colour filters,
// grayscale, threshold and invert. Define IMAGE_PROCESS_SATURATE_EN to clamp brightness.
module image_process (
  input  logic       clka,
  input  logic       reset,
  input  logic [7:0] Rin,
  input  logic [7:0] Gin,
  input  logic [7:0] Bin,
  input  logic [7:0] value,
  input  logic [2:0] operation,
  input  logic       OKin,
  output logic [7:0] Rout,
  output logic [7:0] Gout,
  output logic [7:0] Bout,
  output logic       OKout
);

  localparam int unsigned PIX_W  = 8;
  localparam int unsigned LUMA_W = 18;

  typedef struct packed {
    logic [PIX_W-1:0] r;
    logic [PIX_W-1:0] g;
    logic [PIX_W-1:0] b;
  } pixel_t;

  typedef enum logic [2:0] {
    OP_PASS   = 3'b000,
    OP_BRT_UP = 3'b001,
    OP_BRT_DN = 3'b010,
    OP_RED    = 3'b011,
    OP_GRAY   = 3'b100,
    OP_THRESH = 3'b101,
    OP_INVERT = 3'b110,
    OP_BLUE   = 3'b111
  } op_e;

  localparam logic [PIX_W-1:0] PIX_MAX = {PIX_W{1'b1}};
  localparam logic [PIX_W-1:0] PIX_MIN = '0;

  // Channel + operand; the carry bit decides clamping when saturation is enabled.
  function automatic logic [PIX_W-1:0] brt_up(input logic [PIX_W-1:0] ch,
                                              input logic [PIX_W-1:0] op);
    logic [PIX_W:0] sum;
    sum = (PIX_W+1)'(ch) + (PIX_W+1)'(op);
`ifdef IMAGE_PROCESS_SATURATE_EN
    return sum[PIX_W] ? PIX_MAX : sum[PIX_W-1:0];
`else
    return PIX_W'(sum);
`endif
  endfunction

  // Channel - operand; the borrow bit decides clamping when saturation is enabled.
  function automatic logic [PIX_W-1:0] brt_dn(input logic [PIX_W-1:0] ch,
                                              input logic [PIX_W-1:0] op);
    logic [PIX_W:0] diff;
    diff = (PIX_W+1)'(ch) - (PIX_W+1)'(op);
`ifdef IMAGE_PROCESS_SATURATE_EN
    return diff[PIX_W] ? PIX_MIN : diff[PIX_W-1:0];
`else
    return PIX_W'(diff);
`endif
  endfunction

  pixel_t              pix_in_c;
  pixel_t              pix_res_c;
  pixel_t              pix_q;
  logic [LUMA_W-1:0]   luma_sum_c;
  logic [PIX_W-1:0]    luma_c;
  logic [PIX_W-1:0]    thresh_c;
  logic                ok_q;

  assign pix_in_c = '{r: Rin, g: Gin, b: Bin};

  // BT.601-style integer luma; the weights sum to 256 so the result fits 8 bits.
  always_comb begin
    luma_sum_c = LUMA_W'(77)  * LUMA_W'(Rin)
               + LUMA_W'(150) * LUMA_W'(Gin)
               + LUMA_W'(29)  * LUMA_W'(Bin);
    luma_c     = PIX_W'(luma_sum_c >> 8);
    thresh_c   = (luma_c >= value) ? PIX_MAX : PIX_MIN;
  end

  // Operation select.
  always_comb begin
    pix_res_c = pix_in_c;
    unique case (op_e'(operation))
      OP_PASS:   pix_res_c = pix_in_c;
      OP_BRT_UP: pix_res_c = '{r: brt_up(Rin, value), g: brt_up(Gin, value),
                               b: brt_up(Bin, value)};
      OP_BRT_DN: pix_res_c = '{r: brt_dn(Rin, value), g: brt_dn(Gin, value),
                               b: brt_dn(Bin, value)};
      OP_RED:    pix_res_c = '{r: Rin, g: PIX_MIN, b: PIX_MIN};
      OP_GRAY:   pix_res_c = '{r: luma_c, g: luma_c, b: luma_c};
      OP_THRESH: pix_res_c = '{r: thresh_c, g: thresh_c, b: thresh_c};
      OP_INVERT: pix_res_c = '{r: PIX_MAX - Rin, g: PIX_MAX - Gin, b: PIX_MAX - Bin};
      OP_BLUE:   pix_res_c = '{r: PIX_MIN, g: PIX_MIN, b: Bin};
      default:   pix_res_c = pix_in_c;
    endcase
  end

  // Output registers: load on a valid pixel, otherwise hold data and drop valid.
  always_ff @(posedge clka or negedge reset) begin
    if (!reset) begin
      pix_q <= '0;
      ok_q  <= 1'b0;
    end else begin
      ok_q <= OKin;
      if (OKin) begin
        pix_q <= pix_res_c;
      end
    end
  end

  assign Rout  = pix_q.r;
  assign Gout  = pix_q.g;
  assign Bout  = pix_q.b;
  assign OKout = ok_q;

endmodule

// File: tb/tb_image_process.sv
// Self-checking bench for image_process: directed cases plus a randomized stream
// checked against an integer reference model.
module tb_image_process;

  logic       clka;
  logic       reset;
  logic [7:0] Rin, Gin, Bin, value;
  logic [2:0] operation;
  logic       OKin;
  logic [7:0] Rout, Gout, Bout;
  logic       OKout;

  int checks;
  int failures;

  image_process dut (
    .clka      (clka),
    .reset     (reset),
    .Rin       (Rin),
    .Gin       (Gin),
    .Bin       (Bin),
    .value     (value),
    .operation (operation),
    .OKin      (OKin),
    .Rout      (Rout),
    .Gout      (Gout),
    .Bout      (Bout),
    .OKout     (OKout)
  );

  initial clka = 1'b0;
  always #5 clka = ~clka;

`ifdef IMAGE_PROCESS_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  function automatic int clamp_or_wrap(input int x);
    if (SAT) return (x > 255) ? 255 : ((x < 0) ? 0 : x);
    return ((x % 256) + 256) % 256;
  endfunction

  // Reference model in plain integer arithmetic.
  function automatic logic [23:0] ref_model(input int op, input int r, input int g,
                                            input int b, input int v);
    int y, ro, go, bo;
    y = (77 * r + 150 * g + 29 * b) / 256;
    ro = r; go = g; bo = b;
    case (op)
      1: begin ro = clamp_or_wrap(r + v); go = clamp_or_wrap(g + v); bo = clamp_or_wrap(b + v); end
      2: begin ro = clamp_or_wrap(r - v); go = clamp_or_wrap(g - v); bo = clamp_or_wrap(b - v); end
      3: begin go = 0; bo = 0; end
      4: begin ro = y; go = y; bo = y; end
      5: begin ro = (y >= v) ? 255 : 0; go = ro; bo = ro; end
      6: begin ro = 255 - r; go = 255 - g; bo = 255 - b; end
      7: begin ro = 0; go = 0; end
      default: ;
    endcase
    return {8'(ro), 8'(go), 8'(bo)};
  endfunction

  task automatic tick();
    @(posedge clka);
    #1;
  endtask

  task automatic drive(input logic ok, input logic [2:0] op, input logic [7:0] v,
                       input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
    OKin = ok; operation = op; value = v; Rin = r; Gin = g; Bin = b;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    drive(1'b1, 3'b000, 8'd0, 8'd11, 8'd22, 8'd33);
    tick(); tick();
    checks++;
    if ({OKout, Rout, Gout, Bout} !== 25'd0) begin
      failures++;
      $display("FAIL reset_hold got ok=%0b rgb=%0d,%0d,%0d want ok=0 rgb=0,0,0", OKout, Rout, Gout, Bout);
    end
    reset = 1'b1;
    tick();
    checks++;
    if ({OKout, Rout, Gout, Bout} !== {1'b1, 8'd11, 8'd22, 8'd33}) begin
      failures++;
      $display("FAIL reset_first_pixel got ok=%0b rgb=%0d,%0d,%0d want ok=1 rgb=11,22,33", OKout, Rout, Gout, Bout);
    end
    drive(1'b1, 3'b110, 8'd0, 8'd1, 8'd2, 8'd3);
    tick();
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({OKout, Rout, Gout, Bout} !== 25'd0) begin
      failures++;
      $display("FAIL reset_async got ok=%0b rgb=%0d,%0d,%0d want ok=0 rgb=0,0,0", OKout, Rout, Gout, Bout);
    end
    tick();
    checks++;
    if (OKout !== 1'b0) begin
      failures++;
      $display("FAIL reset_ignores_okin got ok=%0b want 0", OKout);
    end
    reset = 1'b1;
    drive(1'b1, 3'b000, 8'd0, 8'd7, 8'd8, 8'd9);
    tick();
    checks++;
    if ({OKout, Rout, Gout, Bout} !== {1'b1, 8'd7, 8'd8, 8'd9}) begin
      failures++;
      $display("FAIL reset_release got ok=%0b rgb=%0d,%0d,%0d want ok=1 rgb=7,8,9", OKout, Rout, Gout, Bout);
    end
  endtask

  task automatic test_brightness();
    logic [23:0] exp;
    exp = SAT ? {8'd255, 8'd20, 8'd10} : {8'd4, 8'd20, 8'd10};
    drive(1'b1, 3'b001, 8'd10, 8'd250, 8'd10, 8'd0);
    tick();
    checks++;
    if ({OKout, Rout, Gout, Bout} !== {1'b1, exp}) begin
      failures++;
      $display("FAIL bright_up got ok=%0b rgb=%h want ok=1 rgb=%h", OKout, {Rout, Gout, Bout}, exp);
    end
    exp = SAT ? {8'd0, 8'd90, 8'd245} : {8'd251, 8'd90, 8'd245};
    drive(1'b1, 3'b010, 8'd10, 8'd5, 8'd100, 8'd255);
    tick();
    checks++;
    if ({OKout, Rout, Gout, Bout} !== {1'b1, exp}) begin
      failures++;
      $display("FAIL bright_down got ok=%0b rgb=%h want ok=1 rgb=%h", OKout, {Rout, Gout, Bout}, exp);
    end
  endtask

  task automatic test_red_filter();
    drive(1'b0, 3'b000, 8'd0, 8'd0, 8'd0, 8'd0);
    tick();
    drive(1'b1, 3'b011, 8'd0, 8'd12, 8'd34, 8'd56);
    #3;
    checks++;
    if (OKout !== 1'b0) begin
      failures++;
      $display("FAIL red_latency_early got ok=%0b want 0", OKout);
    end
    tick();
    checks++;
    if ({OKout, Rout, Gout, Bout} !== {1'b1, 8'd12, 8'd0, 8'd0}) begin
      failures++;
      $display("FAIL red_filter got ok=%0b rgb=%0d,%0d,%0d want ok=1 rgb=12,0,0", OKout, Rout, Gout, Bout);
    end
  endtask

  task automatic test_gray_threshold();
    drive(1'b1, 3'b100, 8'd0, 8'd100, 8'd150, 8'd200);
    tick();
    checks++;
    if ({Rout, Gout, Bout} !== {8'd140, 8'd140, 8'd140}) begin
      failures++;
      $display("FAIL grayscale got rgb=%0d,%0d,%0d want 140,140,140", Rout, Gout, Bout);
    end
    drive(1'b1, 3'b101, 8'd128, 8'd100, 8'd150, 8'd200);
    tick();
    checks++;
    if ({Rout, Gout, Bout} !== {8'd255, 8'd255, 8'd255}) begin
      failures++;
      $display("FAIL thresh_128 got rgb=%0d,%0d,%0d want 255,255,255", Rout, Gout, Bout);
    end
    drive(1'b1, 3'b101, 8'd141, 8'd100, 8'd150, 8'd200);
    tick();
    checks++;
    if ({Rout, Gout, Bout} !== 24'd0) begin
      failures++;
      $display("FAIL thresh_141 got rgb=%0d,%0d,%0d want 0,0,0", Rout, Gout, Bout);
    end
    drive(1'b1, 3'b101, 8'd140, 8'd100, 8'd150, 8'd200);
    tick();
    checks++;
    if ({Rout, Gout, Bout} !== {8'd255, 8'd255, 8'd255}) begin
      failures++;
      $display("FAIL thresh_equal got rgb=%0d,%0d,%0d want 255,255,255", Rout, Gout, Bout);
    end
  endtask

  task automatic test_back_to_back();
    logic [23:0] px [3];
    logic [23:0] exp [3];
    px[0] = {8'd0, 8'd128, 8'd255};   exp[0] = {8'd255, 8'd127, 8'd0};
    px[1] = {8'd1, 8'd2, 8'd3};       exp[1] = {8'd254, 8'd253, 8'd252};
    px[2] = {8'd255, 8'd255, 8'd255}; exp[2] = 24'd0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 3'b110, 8'd0, px[i][23:16], px[i][15:8], px[i][7:0]);
      tick();
      checks++;
      if ({OKout, Rout, Gout, Bout} !== {1'b1, exp[i]}) begin
        failures++;
        $display("FAIL invert_stream[%0d] got ok=%0b rgb=%h want ok=1 rgb=%h", i, OKout, {Rout, Gout, Bout}, exp[i]);
      end
    end
    drive(1'b0, 3'b000, 8'd99, 8'd9, 8'd9, 8'd9);
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if ({OKout, Rout, Gout, Bout} !== {1'b0, exp[2]}) begin
        failures++;
        $display("FAIL idle_hold[%0d] got ok=%0b rgb=%h want ok=0 rgb=%h", i, OKout, {Rout, Gout, Bout}, exp[2]);
      end
    end
  endtask

  task automatic test_random();
    logic [23:0] exp;
    logic        ok;
    logic [2:0]  op;
    logic [7:0]  v, r, g, b;
    exp = {Rout, Gout, Bout} === 24'd0 ? 24'd0 : 24'd0;
    drive(1'b1, 3'b000, 8'd0, 8'd0, 8'd0, 8'd0);
    tick();
    for (int i = 0; i < 400; i++) begin
      ok = ($urandom_range(0, 3) != 0);
      op = 3'($urandom_range(0, 7));
      v  = 8'($urandom);
      r  = 8'($urandom);
      g  = 8'($urandom);
      b  = 8'($urandom);
      if (i % 50 == 0) begin
        r = 8'd255; g = 8'd0; b = 8'd255; v = 8'd1;
      end
      drive(ok, op, v, r, g, b);
      if (ok) exp = ref_model(int'(op), int'(r), int'(g), int'(b), int'(v));
      tick();
      checks++;
      if ({OKout, Rout, Gout, Bout} !== {ok, exp}) begin
        failures++;
        $display("FAIL random[%0d] op=%0d v=%0d in=%h got ok=%0b rgb=%h want ok=%0b rgb=%h",
                 i, op, v, {r, g, b}, OKout, {Rout, Gout, Bout}, ok, exp);
      end
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    reset = 1'b0;
    drive(1'b0, 3'b000, 8'd0, 8'd0, 8'd0, 8'd0);
    #1;
    test_reset();
    test_brightness();
    test_red_filter();
    test_gray_threshold();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
